// File: rtl/cf_uart_rx_deser_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cf_uart_rx_deser_if : config, FIFO and status bundle of the RX deser     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface cf_uart_rx_deser_if #(
   parameter int MDW = 9
) ();
   logic           en;
   logic           samp_tick;
   logic           rx;
   logic [3:0]     data_size;
   logic [2:0]     parity_type;
   logic           stop_bits2;
   logic [MDW-1:0] match_data;
   logic [5:0]     timeout_bits;
   logic           fifo_full;
   logic [MDW-1:0] rdata;
   logic           wr;
   logic           parity_err;
   logic           frame_err;
   logic           break_det;
   logic           match;
   logic           overrun;
   logic           rx_timeout;
   logic           busy;

   modport master (
      output en, samp_tick, rx, data_size, parity_type, stop_bits2,
             match_data, timeout_bits, fifo_full,
      input  rdata, wr, parity_err, frame_err, break_det, match, overrun,
             rx_timeout, busy
   );

   modport slave (
      input  en, samp_tick, rx, data_size, parity_type, stop_bits2,
             match_data, timeout_bits, fifo_full,
      output rdata, wr, parity_err, frame_err, break_det, match, overrun,
             rx_timeout, busy
   );
endinterface
`default_nettype wire

// File: rtl/cf_uart_rx_deser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cf_uart_rx_deser : 8x oversampling UART receive deserializer             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cf_uart_rx_deser #(
   parameter int MDW         = 9,
   parameter int SC          = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   cf_uart_rx_deser_if.slave bus
);
   localparam int             SCW     = $clog2(SC);
   localparam logic [SCW-1:0] SC_LAST = SCW'(SC - 1);
   localparam logic [SCW-1:0] SC_S3   = SCW'(3);
   localparam logic [SCW-1:0] SC_S4   = SCW'(4);
   localparam logic [SCW-1:0] SC_S5   = SCW'(5);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP1  = 3'd4;
   localparam logic [2:0] S_STOP2  = 3'd5;
   localparam logic [2:0] S_PUSH   = 3'd6;

   logic [SYNC_STAGES-1:0] sync;
   logic                   rxs;
   logic [2:0]             state;
   logic [SCW-1:0]         sc;
   logic [SCW-1:0]         sc_next;
   logic                   s3, s4, maj;
   logic [3:0]             bitcnt;
   logic [3:0]             dsz;
   logic [MDW-1:0]         shreg;
   logic [MDW-1:0]         mask;
   logic                   par_en, exp_par;
   logic                   perr_f, ferr_f, ferr_now, pbit;
   logic                   need_high, to_armed;
   logic [5:0]             idle_cnt;
   logic                   stop_eval;

   assign rxs      = sync[SYNC_STAGES-1];
   assign bus.busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) sync <= '1;
      else        sync <= {sync[SYNC_STAGES-2:0], bus.rx};
   end

   always_comb begin
      dsz     = (bus.data_size >= 4'd5 && bus.data_size <= 4'd9) ? bus.data_size : 4'd8;
      par_en  = 1'b0;
      exp_par = 1'b0;
      case (bus.parity_type)
         3'b001:  begin par_en = 1'b1; exp_par = ~(^shreg); end
         3'b010:  begin par_en = 1'b1; exp_par = ^shreg;    end
         3'b100:  begin par_en = 1'b1; exp_par = 1'b0;      end
         3'b101:  begin par_en = 1'b1; exp_par = 1'b1;      end
         default: begin par_en = 1'b0; exp_par = 1'b0;      end
      endcase
      for (int i = 0; i < MDW; i++) mask[i] = (i < int'(dsz));
      maj       = (s3 & s4) | (s3 & rxs) | (s4 & rxs);
      sc_next   = (sc == SC_LAST) ? '0 : sc + 1'b1;
      ferr_now  = ferr_f | ~maj;
      // Final stop-bit evaluation tick: the frame is committed on this edge.
      stop_eval = bus.samp_tick && (sc == SC_S5) &&
                  ((state == S_STOP2) || (state == S_STOP1 && !bus.stop_bits2));
   end

   always_ff @(posedge clk) begin
      bus.wr         <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.break_det  <= 1'b0;
      bus.match      <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.rx_timeout <= 1'b0;
      if (!rst_n) begin
         state     <= S_IDLE;
         sc        <= '0;
         s3        <= 1'b1;
         s4        <= 1'b1;
         bitcnt    <= '0;
         shreg     <= '0;
         perr_f    <= 1'b0;
         ferr_f    <= 1'b0;
         pbit      <= 1'b0;
         need_high <= 1'b0;
         to_armed  <= 1'b0;
         idle_cnt  <= '0;
         bus.rdata <= '0;
      end else if (!bus.en) begin
         state  <= S_IDLE;
         sc     <= '0;
         perr_f <= 1'b0;
         ferr_f <= 1'b0;
      end else begin
         if (bus.samp_tick && sc == SC_S3) s3 <= rxs;
         if (bus.samp_tick && sc == SC_S4) s4 <= rxs;
         case (state)
            S_IDLE: begin
               if (rxs) need_high <= 1'b0;
               if (bus.samp_tick) begin
                  if (!rxs && !need_high) begin
                     state    <= S_START;
                     sc       <= '0;
                     idle_cnt <= '0;
                     shreg    <= '0;
                     bitcnt   <= '0;
                     perr_f   <= 1'b0;
                     ferr_f   <= 1'b0;
                     pbit     <= 1'b0;
                  end else if (rxs) begin
                     sc <= sc_next;
                     if (sc == SC_LAST && to_armed) begin
                        if (idle_cnt != 6'h3f) idle_cnt <= idle_cnt + 6'd1;
                        if (bus.timeout_bits != 6'd0 && idle_cnt + 6'd1 == bus.timeout_bits) begin
                           bus.rx_timeout <= 1'b1;
                           to_armed       <= 1'b0;
                        end
                     end
                  end
               end
            end
            S_START: if (bus.samp_tick) begin
               sc <= sc_next;
               if (sc == SC_S5 && maj) begin
                  state <= S_IDLE;
                  sc    <= '0;
               end else if (sc == SC_LAST) begin
                  state <= S_DATA;
               end
            end
            S_DATA: if (bus.samp_tick) begin
               sc <= sc_next;
               if (sc == SC_S5) begin
                  for (int i = 0; i < MDW; i++)
                     if (bitcnt == 4'(i)) shreg[i] <= maj;
                  bitcnt <= bitcnt + 4'd1;
               end
               if (sc == SC_LAST && bitcnt == dsz) state <= par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: if (bus.samp_tick) begin
               sc <= sc_next;
               if (sc == SC_S5) begin
                  pbit <= maj;
                  if (maj != exp_par) perr_f <= 1'b1;
               end
               if (sc == SC_LAST) state <= S_STOP1;
            end
            S_STOP1, S_STOP2: if (bus.samp_tick) begin
               sc <= sc_next;
               if (sc == SC_S5 && !maj) ferr_f <= 1'b1;
               if (sc == SC_LAST) state <= S_STOP2;
            end
            default: state <= S_IDLE;
         endcase
         if (stop_eval) begin
            state          <= S_PUSH;
            sc             <= '0;
            bus.parity_err <= perr_f;
            bus.frame_err  <= ferr_now;
            bus.break_det  <= (shreg == '0) && ferr_now && !pbit;
            need_high      <= ferr_now;
            to_armed       <= 1'b1;
            idle_cnt       <= '0;
            if (!bus.fifo_full) begin
               bus.wr    <= 1'b1;
               bus.rdata <= shreg;
               bus.match <= (shreg == (bus.match_data & mask));
            end else begin
               bus.overrun <= 1'b1;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_cf_uart_rx_deser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cf_uart_rx_deser : randomized self-checking bench for the RX deser    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cf_uart_rx_deser;
   localparam int MDW = 9;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cf_uart_rx_deser_if #(.MDW(MDW)) bus ();
   cf_uart_rx_deser #(.MDW(MDW), .SC(8), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic       wr, ov;
      logic [8:0] rdata;
      logic       perr, ferr, brk, mt;
      int         tick;
   } ev_t;

   int   tests = 0, fails = 0;
   int   pr = 10, pcnt = 0, tick_cnt = 0, stray = 0;
   ev_t  evq[$];
   int   toq[$];

   // Output monitor and prescaler tick generator share the falling edge.
   always @(negedge clk) begin
      ev_t e;
      if (bus.wr || bus.overrun) begin
         e.wr = bus.wr; e.ov = bus.overrun; e.rdata = bus.rdata;
         e.perr = bus.parity_err; e.ferr = bus.frame_err;
         e.brk = bus.break_det; e.mt = bus.match; e.tick = tick_cnt;
         evq.push_back(e);
      end else if (bus.parity_err || bus.frame_err || bus.break_det || bus.match) begin
         stray++;
      end
      if (bus.rx_timeout) toq.push_back(tick_cnt);
      if (pcnt >= pr) begin bus.samp_tick = 1'b1; pcnt = 0; tick_cnt++; end
      else begin bus.samp_tick = 1'b0; pcnt++; end
   end

   function automatic logic [14:0] pk(input ev_t e);
      return {e.wr, e.ov, e.rdata, e.perr, e.ferr, e.brk, e.mt};
   endfunction

   function automatic int eff_size(input logic [3:0] ds);
      return (ds >= 4'd5 && ds <= 4'd9) ? int'(ds) : 8;
   endfunction

   function automatic logic par_on(input logic [2:0] pt);
      return (pt == 3'b001) || (pt == 3'b010) || (pt == 3'b100) || (pt == 3'b101);
   endfunction

   function automatic logic par_val(input logic [2:0] pt, input logic [8:0] d);
      int ones = $countones(d);
      case (pt)
         3'b001:  return (ones % 2) == 0;
         3'b010:  return (ones % 2) == 1;
         3'b101:  return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [8:0] size_mask();
      logic [9:0] full = 10'((1 << eff_size(bus.data_size)) - 1);
      return full[8:0];
   endfunction

   // Expected FIFO-side event for one frame under the current line config.
   function automatic logic [14:0] model_ev(input logic [8:0] d, input logic flip,
                                             input logic bad1, input logic bad2,
                                             input logic full, input logic [8:0] prev);
      logic [8:0] m   = size_mask();
      logic [8:0] dm  = d & m;
      logic       pen = par_on(bus.parity_type);
      logic       pb  = pen ? (par_val(bus.parity_type, dm) ^ flip) : 1'b0;
      logic       fe  = bad1 || (bus.stop_bits2 && bad2);
      logic       br  = (dm == 9'd0) && fe && !pb;
      logic       mt  = !full && (dm == (bus.match_data & m));
      return {!full, full, full ? prev : dm, pen && flip, fe, br, mt};
   endfunction

   task automatic drive_bit(input logic v, input int clks);
      bus.rx = v;
      repeat (clks) @(negedge clk);
   endtask

   task automatic send_frame(input logic [8:0] d, input logic flip,
                             input logic bad1, input logic bad2);
      int         bt = 8 * (pr + 1);
      int         n  = eff_size(bus.data_size);
      logic [8:0] dm = d & size_mask();
      drive_bit(1'b0, bt);
      for (int i = 0; i < n; i++) drive_bit(dm[i], bt);
      if (par_on(bus.parity_type)) drive_bit(par_val(bus.parity_type, dm) ^ flip, bt);
      drive_bit(!bad1, bt);
      if (bus.stop_bits2) drive_bit(!bad2, bt);
      drive_bit(1'b1, 2 * bt);
   endtask

   task automatic cfg(input int p, input logic [3:0] ds, input logic [2:0] pt, input logic s2);
      pr = p; bus.data_size = ds; bus.parity_type = pt; bus.stop_bits2 = s2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.en = 1'b1; bus.rx = 1'b1; bus.fifo_full = 1'b0;
      bus.match_data = 9'h1FF; bus.timeout_bits = 6'd0;
      cfg(10, 4'd8, 3'b000, 1'b0);
      repeat (3) @(negedge clk);
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      tests++; if (bus.wr !== 1'b0) begin fails++; $display("FAIL reset_wr: got %b expected 0", bus.wr); end
      tests++; if (bus.rdata !== 9'h000) begin fails++; $display("FAIL reset_rdata: got %h expected 000", bus.rdata); end
      tests++; if ({bus.overrun, bus.rx_timeout, bus.frame_err} !== 3'b000) begin
         fails++; $display("FAIL reset_pulses: got %b expected 000", {bus.overrun, bus.rx_timeout, bus.frame_err});
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic_8n1();
      logic [14:0] exp_e;
      cfg(10, 4'd8, 3'b000, 1'b0);
      evq.delete();
      exp_e = model_ev(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
      send_frame(9'h0A5, 1'b0, 1'b0, 1'b0);
      tests++; if (evq.size() != 1) begin fails++; $display("FAIL basic_count: got %0d expected 1", evq.size()); end
      else begin
         tests++; if (pk(evq[0]) !== exp_e) begin fails++; $display("FAIL basic_event: got %h expected %h", pk(evq[0]), exp_e); end
      end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_parity_even_2stop();
      logic [14:0] e0, e1;
      cfg(10, 4'd8, 3'b010, 1'b1);
      evq.delete();
      e0 = model_ev(9'h0C3, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
      e1 = model_ev(9'h091, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000);
      send_frame(9'h0C3, 1'b0, 1'b0, 1'b0);
      send_frame(9'h091, 1'b1, 1'b0, 1'b0);
      tests++; if (evq.size() != 2) begin fails++; $display("FAIL parity_count: got %0d expected 2", evq.size()); end
      else begin
         tests++; if (pk(evq[0]) !== e0) begin fails++; $display("FAIL parity_c3: got %h expected %h", pk(evq[0]), e0); end
         tests++; if (pk(evq[1]) !== e1) begin fails++; $display("FAIL parity_91: got %h expected %h", pk(evq[1]), e1); end
      end
   endtask

   task automatic test_break();
      int          bt = 8 * 11;
      logic [14:0] exp_e;
      cfg(10, 4'd8, 3'b000, 1'b0);
      bus.match_data = 9'h1FF;
      evq.delete();
      exp_e = model_ev(9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000);
      drive_bit(1'b0, 12 * bt);
      drive_bit(1'b1, 3 * bt);
      tests++; if (evq.size() != 1) begin fails++; $display("FAIL break_count: got %0d expected 1", evq.size()); end
      else begin
         tests++; if (pk(evq[0]) !== exp_e) begin fails++; $display("FAIL break_event: got %h expected %h", pk(evq[0]), exp_e); end
      end
   endtask

   task automatic test_glitch_match();
      logic [14:0] exp_e;
      cfg(10, 4'd8, 3'b000, 1'b0);
      evq.delete();
      drive_bit(1'b0, 2 * (pr + 1));
      drive_bit(1'b1, 8 * (pr + 1) + 4);
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b expected 0", bus.busy); end
      tests++; if (evq.size() != 0) begin fails++; $display("FAIL glitch_events: got %0d expected 0", evq.size()); end
      bus.match_data = 9'h091;
      exp_e = model_ev(9'h091, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
      send_frame(9'h091, 1'b0, 1'b0, 1'b0);
      tests++; if (evq.size() != 1) begin fails++; $display("FAIL match_count: got %0d expected 1", evq.size()); end
      else begin
         tests++; if (pk(evq[0]) !== exp_e) begin fails++; $display("FAIL match_event: got %h expected %h", pk(evq[0]), exp_e); end
      end
   endtask

   task automatic test_overrun();
      logic [14:0] exp_e;
      cfg(10, 4'd8, 3'b000, 1'b0);
      bus.match_data = 9'h1FF;
      evq.delete();
      send_frame(9'h033, 1'b0, 1'b0, 1'b0);
      bus.fifo_full = 1'b1;
      exp_e = model_ev(9'h05A, 1'b0, 1'b0, 1'b0, 1'b1, 9'h033);
      send_frame(9'h05A, 1'b0, 1'b0, 1'b0);
      bus.fifo_full = 1'b0;
      tests++; if (evq.size() != 2) begin fails++; $display("FAIL overrun_count: got %0d expected 2", evq.size()); end
      else begin
         tests++; if (pk(evq[1]) !== exp_e) begin fails++; $display("FAIL overrun_event: got %h expected %h", pk(evq[1]), exp_e); end
      end
      tests++; if (bus.rdata !== 9'h033) begin fails++; $display("FAIL overrun_hold: got %h expected 033", bus.rdata); end
   endtask

   task automatic test_reset_timeout();
      int          bt = 8 * 11;
      logic [14:0] exp_e;
      cfg(10, 4'd8, 3'b000, 1'b0);
      bus.timeout_bits = 6'd4;
      evq.delete();
      toq.delete();
      drive_bit(1'b0, bt);
      drive_bit(1'b1, bt);
      drive_bit(1'b0, bt / 2);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.rx = 1'b1;
      @(negedge clk);
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
      drive_bit(1'b1, 12 * bt);
      tests++; if (toq.size() != 0) begin fails++; $display("FAIL timeout_unarmed: got %0d expected 0", toq.size()); end
      exp_e = model_ev(9'h03C, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000);
      send_frame(9'h03C, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10 * bt && toq.size() == 0; i++) @(negedge clk);
      tests++; if (evq.size() != 1) begin fails++; $display("FAIL rst_mid_count: got %0d expected 1", evq.size()); end
      else begin
         tests++; if (pk(evq[0]) !== exp_e) begin fails++; $display("FAIL rst_mid_event: got %h expected %h", pk(evq[0]), exp_e); end
      end
      tests++; if (toq.size() != 1) begin fails++; $display("FAIL timeout_count: got %0d expected 1", toq.size()); end
      else if (evq.size() == 1) begin
         tests++; if (toq[0] - evq[0].tick != 32) begin
            fails++; $display("FAIL timeout_ticks: got %0d expected 32", toq[0] - evq[0].tick);
         end
      end
      drive_bit(1'b1, 6 * bt);
      tests++; if (toq.size() != 1) begin fails++; $display("FAIL timeout_rearm: got %0d expected 1", toq.size()); end
      bus.timeout_bits = 6'd0;
   endtask

   task automatic test_random_frames();
      int          prs[4] = '{0, 1, 3, 10};
      logic [8:0]  prev = 9'h000, d, m;
      logic        have_prev = 1'b0, flip, bad1, bad2, full;
      logic [14:0] exp_e;
      for (int f = 0; f < 30; f++) begin
         cfg(prs[$urandom_range(0, 3)],
             ($urandom_range(0, 3) != 0) ? 4'($urandom_range(5, 9)) : 4'($urandom_range(0, 15)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         d    = 9'($urandom);
         m    = size_mask();
         flip = ($urandom_range(0, 3) == 0);
         bad1 = ($urandom_range(0, 5) == 0);
         bad2 = ($urandom_range(0, 5) == 0);
         full = have_prev && ($urandom_range(0, 7) == 0);
         bus.match_data = ($urandom_range(0, 1) != 0) ? ((d & m) | (9'($urandom) & ~m)) : 9'($urandom);
         bus.fifo_full  = full;
         repeat (2) @(negedge clk);
         exp_e = model_ev(d, flip, bad1, bad2, full, prev);
         evq.delete();
         send_frame(d, flip, bad1, bad2);
         bus.fifo_full = 1'b0;
         tests++; if (evq.size() != 1) begin fails++; $display("FAIL rand_count[%0d]: got %0d expected 1", f, evq.size()); end
         else begin
            tests++; if (pk(evq[0]) !== exp_e) begin
               fails++; $display("FAIL rand_event[%0d]: got %h expected %h", f, pk(evq[0]), exp_e);
            end
         end
         if (!full) begin prev = d & m; have_prev = 1'b1; end
      end
   endtask

   task automatic test_no_stray_pulses();
      tests++; if (stray != 0) begin fails++; $display("FAIL stray_pulses: got %0d expected 0", stray); end
   endtask

   initial begin
      test_reset();
      test_basic_8n1();
      test_parity_even_2stop();
      test_break();
      test_glitch_match();
      test_overrun();
      test_reset_timeout();
      test_random_frames();
      test_no_stray_pulses();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/cf_uart_rx_deser.md
Name: cf_uart_rx_deser

Overview:
Receive-side deserializer of the CF_UART core. It sits between the `rx` pin and the RX FIFO that backs the RXDATA register. It oversamples `rx` using the prescaler's sample tick (8 ticks per bit) and recovers 5–9-bit frames with optional parity and 1 or 2 stop bits. Each frame is pushed to the FIFO together with per-frame error, break, match and overrun status for the interrupt logic (RIS).

Parameters:
MDW, 9, maximum data width; width of `rdata` and `match_data`.
SC, 8, sample ticks per bit; fixed at 8 so that baud = clk/((PR+1)*8).
SYNC_STAGES, 2, flip-flop stages in the `rx` synchronizer.

Ports:
clk  input  1  core clock.
rst_n  input  1  reset; synchronous, active-low.
en  input  1  receiver enable (CTRL.EN & CTRL.RXEN); 0 forces IDLE.
samp_tick  input  1  one-clk pulse every (PR+1) clocks from the prescaler.
rx  input  1  asynchronous serial line; idle high.
data_size  input  4  data bits; valid range 5..9; values outside that range are treated as 8.
parity_type  input  3  000 none, 001 odd, 010 even, 100 stick-0, 101 stick-1; other codes are treated as none.
stop_bits2  input  1  1 = two stop bits checked.
match_data  input  MDW  compare value for the match flag.
timeout_bits  input  6  idle bit-times after a frame before `rx_timeout` fires; 0 disables.
fifo_full  input  1  RX FIFO full.
rdata  output  MDW  received data, LSB-aligned, zero-extended above data_size.
wr  output  1  one-clk FIFO push strobe.
parity_err  output  1  one-clk pulse, coincident with `wr` or the overrun pulse.
frame_err  output  1  one-clk pulse, coincident with `wr` or the overrun pulse.
break_det  output  1  one-clk pulse; break frame detected.
match  output  1  one-clk pulse; pushed `rdata` == `match_data`.
overrun  output  1  one-clk pulse; frame dropped because `fifo_full`.
rx_timeout  output  1  one-clk pulse on idle timeout.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low at a clk edge): FSM goes to IDLE; sync chain set to 1; all counters cleared; `rdata` = 0; all pulse outputs 0; `busy` = 0. Reset mid-frame abandons the frame silently.
- `rx` passes through SYNC_STAGES flops (reset value 1). All logic below uses the synchronized value `rxs`.
- Sample counter `sc` (0..7) advances only on `samp_tick`. Bit value = majority of `rxs` sampled at sc = 3, 4, 5; it is evaluated on the tick where sc = 5.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH.
  - IDLE: on a tick with `rxs` = 0 and `en` = 1, go to START with sc = 0.
  - START: if the start-bit majority is 1 (false start or glitch), return to IDLE with no output; otherwise go to DATA after sc = 7.
  - DATA: shift LSB-first into a shift register; a bit counter counts `data_size` bits. Then go to PARITY if parity is enabled, else STOP1.
  - PARITY: compute expected parity (odd: XOR of data ^ 1; even: XOR of data; stick-0: 0; stick-1: 1). A mismatch latches a parity-error flag.
  - STOP1: a majority of 0 latches a frame-error flag. If `stop_bits2`, wait to sc = 7 and go to STOP2; else go to PUSH right after the sc = 5 evaluation.
  - STOP2: same check as STOP1, then go to PUSH.
  - PUSH: lasts one clk, then IDLE.
- PUSH cycle outputs:
  - If `fifo_full` = 0: assert `wr`, update `rdata`, and pulse the latched error flags.
  - If `fifo_full` = 1: no `wr`; `rdata` is unchanged; pulse `overrun`; error flags still pulse.
  - `match` pulses only when `wr` is asserted and data equals `match_data` (compare on data_size bits).
  - `break_det` pulses when data = 0, frame error is set, and the parity bit (if any) = 0. A break frame is still pushed.
- After a frame ends early on a stop-bit error, a new start is accepted only after `rxs` is seen high (no retrigger on a held-low line).
- Timeout: an idle-bit counter increments every 8 ticks while in IDLE with `rxs` = 1. It clears on any start. `rx_timeout` pulses once when the count equals `timeout_bits` (non-zero), counting only from a completed PUSH; it re-arms only after the next frame.
- `en` falling: the FSM goes to IDLE on the next clk and pending flags are discarded; `rdata` is held.
- `samp_tick` asserted every clk (PR = 0) is legal.
- Latency: `wr` is asserted 1 clk after the tick that evaluates the last stop bit.

Test Plan:
- PR = 10 (tick every 11 clk); 8N1; drive 0xA5 at bit time 88 clk → exactly one `wr`, `rdata` = 0x0A5, no error pulses, `busy` low afterwards.
- 8, even parity, 2 stop bits; frames 0xC3 then 0x91, where 0x91 is sent with a flipped parity bit → two `wr`; `parity_err` pulses only with 0x91.
- `rx` low for 12 bit-times (8N1) → one `wr` with `rdata` = 0x000, `frame_err` = 1, `break_det` = 1; no second frame until the line goes high.
- 2-tick low glitch on idle `rx` → no `wr`, `busy` returns to 0 within 8 ticks; then `match_data` = 0x091 and frame 0x91 sent → `match` pulse together with `wr`.
- `fifo_full` = 1 while 0x5A is received → `overrun` pulse, no `wr`, `rdata` holds the previous value.
- `rst_n` low for 1 clk mid-DATA, then 0x3C sent; separately, `timeout_bits` = 4 → only 0x3C pushed after the reset; `rx_timeout` pulses 32 ticks after the 0x3C PUSH.
